// File: rtl/serial_sum_collector_pkg.sv
// Shared constants for the bit-serial adder datapath and its collector.
package serial_sum_collector_pkg;

  // Operand/sum width shared by bit_serial_adder, this collector and their benches.
  localparam int SSC_WIDTH = 8;
  localparam int SSC_CNT_W = $clog2(SSC_WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_sum_collector_bit_counter.sv
// Bit-position counter for the serial collector; flags the MSB position.
module serial_bit_counter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic last
);

  logic [CNT_W-1:0] cnt;

  assign last = (cnt == CNT_W'(WIDTH - 1));

  // Count collected bits; wrap to 0 after the MSB so cnt never exceeds WIDTH-1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          cnt <= '0;
    else if (clr)      cnt <= '0;
    else if (en)       cnt <= last ? '0 : cnt + 1'b1;
  end

endmodule

// File: rtl/serial_sum_collector.sv
// Deserialises the LSB-first sum stream of bit_serial_adder into a parallel
// word plus final carry, offered downstream with a valid/ready handshake.
module serial_sum_collector
  import serial_sum_collector_pkg::*;
#(
  parameter int WIDTH = SSC_WIDTH,
  parameter int CNT_W = SSC_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sum_bit,
  input  logic             carry_bit,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum_word,
  output logic             carry_out,
  output logic             out_valid,
  output logic             busy,
  output logic             overrun
);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shift_nxt;
  logic             last;
  logic             cnt_clr, cnt_en;
  logic             shreg_clr, shift_en;
  logic             load, valid_clr, ovr_set;

  // New bit enters at the MSB so the LSB-first stream lands in natural order.
  assign shift_nxt = {sum_bit, shreg[WIDTH-1:1]};

  serial_bit_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .last (last)
  );

  // Next-state and datapath control decode.
  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    shreg_clr = 1'b0;
    shift_en  = 1'b0;
    load      = 1'b0;
    valid_clr = 1'b0;
    ovr_set   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_SHIFT;
          cnt_clr   = 1'b1;
          shreg_clr = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (start) begin
          // Restart: the partial result is silently dropped.
          cnt_clr   = 1'b1;
          shreg_clr = 1'b1;
        end else begin
          shift_en = 1'b1;
          cnt_en   = 1'b1;
          if (last) begin
            load      = 1'b1;
            state_nxt = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          valid_clr = 1'b1;
          if (start) begin
            state_nxt = ST_SHIFT;
            cnt_clr   = 1'b1;
            shreg_clr = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
          end
        end else if (start) begin
          // Result still pending: the new addition is lost, remember that.
          ovr_set = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, shift register and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      shreg     <= '0;
      sum_word  <= '0;
      carry_out <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == ST_SHIFT);
      if (shreg_clr)     shreg <= '0;
      else if (shift_en) shreg <= shift_nxt;
      if (load) begin
        sum_word  <= shift_nxt;
        carry_out <= carry_bit;
        out_valid <= 1'b1;
      end else if (valid_clr) begin
        out_valid <= 1'b0;
      end
      if (ovr_set) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_serial_sum_collector.sv
// Directed bench for serial_sum_collector.
module tb_serial_sum_collector;
  import serial_sum_collector_pkg::*;

  localparam int W = SSC_WIDTH;

  logic         clk = 1'b0;
  logic         rst;
  logic         start, sum_bit, carry_bit, out_ready;
  logic [W-1:0] sum_word;
  logic         carry_out, out_valid, busy, overrun;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_sum_collector dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sum_bit   (sum_bit),
    .carry_bit (carry_bit),
    .out_ready (out_ready),
    .sum_word  (sum_word),
    .carry_out (carry_out),
    .out_valid (out_valid),
    .busy      (busy),
    .overrun   (overrun)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Raise start for one edge (driven at a falling edge).
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
  endtask

  // Feed n sum bits LSB first; carry asserted with the MSB. Returns at the
  // falling edge after the edge that sampled the last bit.
  task automatic stream(input logic [W-1:0] s, input logic c, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == 0) begin
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("valid_low_at_start", 32'(out_valid), 32'd0);
      end
      if (i == W - 1) chk("valid_not_early", 32'(out_valid), 32'd0);
      start     = 1'b0;
      sum_bit   = s[i];
      carry_bit = (i == W - 1) ? c : 1'b0;
    end
    @(negedge clk);
    sum_bit   = 1'b0;
    carry_bit = 1'b0;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; sum_bit = 1'b0; carry_bit = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_sum", 32'(sum_word), 32'h0);
    chk("rst_carry", 32'(carry_out), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    rst = 1'b1;

    // T1: 6+14 = 20, zero-wait consumer
    out_ready = 1'b1;
    pulse_start();
    stream(8'b0001_0100, 1'b0, W);
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_sum", 32'(sum_word), 32'h14);
    chk("t1_carry", 32'(carry_out), 32'd0);
    chk("t1_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("t1_valid_drop", 32'(out_valid), 32'd0);
    chk("t1_idle_busy", 32'(busy), 32'd0);

    // T2: FF + 01 -> 00 carry 1
    pulse_start();
    stream(8'h00, 1'b1, W);
    chk("t2_valid", 32'(out_valid), 32'd1);
    chk("t2_sum", 32'(sum_word), 32'h00);
    chk("t2_carry", 32'(carry_out), 32'd1);
    @(negedge clk);

    // T3: consumer stalls 5 cycles
    out_ready = 1'b0;
    pulse_start();
    stream(8'h3C, 1'b0, W);
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_valid", 32'(out_valid), 32'd1);
      chk("t3_hold_sum", 32'(sum_word), 32'h3C);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("t3_drop", 32'(out_valid), 32'd0);

    // T4: start during HOLD with no ready -> overrun, result intact
    out_ready = 1'b0;
    pulse_start();
    stream(8'h5A, 1'b1, W);
    chk("t4_valid", 32'(out_valid), 32'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t4_overrun", 32'(overrun), 32'd1);
    chk("t4_still_valid", 32'(out_valid), 32'd1);
    chk("t4_sum_kept", 32'(sum_word), 32'h5A);
    chk("t4_carry_kept", 32'(carry_out), 32'd1);
    chk("t4_not_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("t4_still_hold", 32'(out_valid), 32'd1);
    rst = 1'b0;
    #1;
    chk("t4_rst_overrun", 32'(overrun), 32'd0);
    chk("t4_rst_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // T5: restart after 4 bits of a stream of ones, then A5
    pulse_start();
    stream(8'hFF, 1'b0, 4);
    start = 1'b1;
    @(negedge clk);
    chk("t5_busy_restart", 32'(busy), 32'd1);
    chk("t5_no_valid", 32'(out_valid), 32'd0);
    start = 1'b1;
    stream(8'hA5, 1'b0, W);
    chk("t5_valid", 32'(out_valid), 32'd1);
    chk("t5_sum", 32'(sum_word), 32'hA5);

    // T6: start with out_ready in HOLD -> back-to-back
    start = 1'b1;
    out_ready = 1'b1;
    stream(8'h81, 1'b1, W);
    chk("t6_valid", 32'(out_valid), 32'd1);
    chk("t6_sum", 32'(sum_word), 32'h81);
    chk("t6_carry", 32'(carry_out), 32'd1);
    @(negedge clk);
    chk("t6_drop", 32'(out_valid), 32'd0);

    // Asynchronous reset mid-SHIFT
    pulse_start();
    stream(8'hFF, 1'b0, 3);
    chk("mid_busy", 32'(busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_sum", 32'(sum_word), 32'h0);
    chk("arst_carry", 32'(carry_out), 32'd0);
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_overrun", 32'(overrun), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
